// File: rtl/iob_eth_mii_chan.sv
// MII/GMII loopback channel: TX is fed back to RX through a fixed-depth delay line.
// It can drop whole frames, flag one nibble with rx_er, and counts frames and lengths.
module iob_eth_mii_chan #(
  parameter int DATA_W = 4,
  parameter int DELAY  = 2,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cfg_en_i,
  input  logic [7:0]        drop_every_i,
  input  logic [CNT_W-1:0]  err_idx_i,
  input  logic [DATA_W-1:0] tx_d_i,
  input  logic              tx_en_i,
  input  logic              tx_er_i,
  output logic [DATA_W-1:0] rx_d_o,
  output logic              rx_dv_o,
  output logic              rx_er_o,
  output logic [CNT_W-1:0]  frames_fwd_o,
  output logic [CNT_W-1:0]  frames_drop_o,
  output logic [CNT_W-1:0]  last_len_o,
  output logic              busy_o
);
  typedef enum logic [1:0] {SYNC, IDLE, FWD, DROP} st_t;
  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic              dv;
    logic              er;
  } nib_t;

  localparam logic [CNT_W-1:0] CMAX = '1;

  st_t              st_q, st_d;
  logic [CNT_W-1:0] nib_q, nib_d, fwd_q, fwd_d, drp_q, drp_d, len_q, len_d;
  logic [7:0]       dcnt_q, dcnt_d;
  nib_t [DELAY-1:0] dly_q;
  nib_t             stg0;
  logic             drop_dec, inj;

  always_comb begin
    st_d     = st_q;
    nib_d    = nib_q;
    fwd_d    = fwd_q;
    drp_d    = drp_q;
    len_d    = len_q;
    dcnt_d   = dcnt_q;
    stg0     = '0;
    drop_dec = !cfg_en_i || (drop_every_i != 8'd0 && (dcnt_q + 8'd1) == drop_every_i);
    case (st_q)
      SYNC: if (!tx_en_i) st_d = IDLE;
      IDLE: if (tx_en_i) begin
        nib_d = {{(CNT_W-1){1'b0}}, 1'b1};
        if (drop_dec) begin
          st_d = DROP;
          // a frame dropped for cfg_en_i=0 leaves the Nth-frame counter untouched
          if (cfg_en_i) dcnt_d = 8'd0;
        end else begin
          st_d = FWD;
          if (drop_every_i != 8'd0) dcnt_d = dcnt_q + 8'd1;
        end
      end
      default: begin
        if (tx_en_i) begin
          if (nib_q != CMAX) nib_d = nib_q + 1'b1;
        end else begin
          len_d = nib_q;
          st_d  = IDLE;
          if (st_q == FWD) begin
            if (fwd_q != CMAX) fwd_d = fwd_q + 1'b1;
          end else begin
            if (drp_q != CMAX) drp_d = drp_q + 1'b1;
          end
        end
      end
    endcase
    inj = (err_idx_i != '0) && (nib_d == err_idx_i);
    // st_d==FWD with tx_en_i high covers both the start cycle and the frame body
    if (tx_en_i && st_d == FWD) stg0 = '{d: tx_d_i, dv: 1'b1, er: tx_er_i | inj};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      st_q   <= SYNC;
      nib_q  <= '0;
      fwd_q  <= '0;
      drp_q  <= '0;
      len_q  <= '0;
      dcnt_q <= '0;
      dly_q  <= '0;
    end else begin
      st_q     <= st_d;
      nib_q    <= nib_d;
      fwd_q    <= fwd_d;
      drp_q    <= drp_d;
      len_q    <= len_d;
      dcnt_q   <= dcnt_d;
      dly_q[0] <= stg0;
      for (int i = 1; i < DELAY; i++) dly_q[i] <= dly_q[i-1];
    end
  end

  assign rx_d_o        = dly_q[DELAY-1].d;
  assign rx_dv_o       = dly_q[DELAY-1].dv;
  assign rx_er_o       = dly_q[DELAY-1].er;
  assign frames_fwd_o  = fwd_q;
  assign frames_drop_o = drp_q;
  assign last_len_o    = len_q;
  assign busy_o        = (st_q == FWD) || (st_q == DROP);
endmodule

// File: tb/tb_iob_eth_mii_chan.sv
// Directed bench for iob_eth_mii_chan (DATA_W=4, DELAY=2, CNT_W=16).
module tb_iob_eth_mii_chan;
  logic        clk = 1'b0, rst = 1'b0, cfg_en = 1'b1, tx_en = 1'b0, tx_er = 1'b0;
  logic [7:0]  drop_every = 8'd0;
  logic [15:0] err_idx = 16'd0;
  logic [3:0]  tx_d = 4'd0;
  logic [3:0]  rx_d;
  logic        rx_dv, rx_er, busy;
  logic [15:0] fwd, drp, len;

  int checks = 0, failures = 0, cyc = 0, first_dv = -1, last_dv = -1, t0 = 0;
  logic [3:0] rxq[$];
  logic       erq[$];

  iob_eth_mii_chan #(.DATA_W(4), .DELAY(2), .CNT_W(16)) dut (
    .clk_i(clk), .rst_i(rst), .cfg_en_i(cfg_en), .drop_every_i(drop_every),
    .err_idx_i(err_idx), .tx_d_i(tx_d), .tx_en_i(tx_en), .tx_er_i(tx_er),
    .rx_d_o(rx_d), .rx_dv_o(rx_dv), .rx_er_o(rx_er), .frames_fwd_o(fwd),
    .frames_drop_o(drp), .last_len_o(len), .busy_o(busy));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (rx_dv) begin
    rxq.push_back(rx_d);
    erq.push_back(rx_er);
    if (first_dv < 0) first_dv = cyc;
    last_dv = cyc;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    tx_en = 1'b0; tx_d = 4'd0;
    repeat (n) step();
  endtask

  task automatic clr();
    rxq.delete(); erq.delete(); first_dv = -1; last_dv = -1;
  endtask

  task automatic do_reset();
    rst = 1'b1; step(); step(); rst = 1'b0;
    idle(1); clr();
  endtask

  task automatic send(input int n, input int base, input bit inc);
    for (int i = 0; i < n; i++) begin
      tx_d = 4'(inc ? base + i : base); tx_en = 1'b1; step();
    end
    tx_en = 1'b0; tx_d = 4'd0;
  endtask

  function automatic int er_count();
    int c = 0;
    foreach (erq[i]) c += int'(erq[i]);
    return c;
  endfunction

  initial begin
    int ids[4] = '{1, 2, 4, 5};
    // reset values
    rst = 1'b1; step(); step();
    chk("rst_dv", int'(rx_dv), 0);   chk("rst_fwd", int'(fwd), 0);
    chk("rst_drop", int'(drp), 0);   chk("rst_len", int'(len), 0);
    chk("rst_busy", int'(busy), 0);
    rst = 1'b0; idle(2); clr();

    // 8-nibble frame 1..8
    t0 = cyc; send(8, 1, 1'b1); idle(6);
    chk("t1_latency", first_dv - t0, 2);
    chk("t1_span", last_dv - first_dv, 7);
    chk("t1_size", rxq.size(), 8);
    foreach (rxq[i]) chk("t1_data", int'(rxq[i]), i + 1);
    chk("t1_fwd", int'(fwd), 1); chk("t1_len", int'(len), 8); chk("t1_drop", int'(drp), 0);

    // drop every 3rd frame
    do_reset(); drop_every = 8'd3;
    for (int f = 1; f <= 6; f++) begin send(4, f, 1'b0); idle(1); end
    idle(5);
    chk("t2_size", rxq.size(), 16);
    foreach (rxq[i]) if (i < 16) chk("t2_data", int'(rxq[i]), ids[i/4]);
    chk("t2_fwd", int'(fwd), 4); chk("t2_drop", int'(drp), 2); chk("t2_len", int'(len), 4);
    drop_every = 8'd0;

    // error injection on nibble 5, then index past frame end
    do_reset(); err_idx = 16'd5;
    send(10, 0, 1'b1); idle(5);
    chk("t3_size", rxq.size(), 10); chk("t3_ercnt", er_count(), 1);
    chk("t3_er5", (erq.size() > 4) ? int'(erq[4]) : -1, 1);
    clr(); err_idx = 16'd12;
    send(10, 0, 1'b1); idle(5);
    chk("t3b_size", rxq.size(), 10); chk("t3b_ercnt", er_count(), 0);
    chk("t3b_len", int'(len), 10);
    err_idx = 16'd0;

    // frame in flight across reset release is discarded
    tx_en = 1'b1; tx_d = 4'hF; rst = 1'b1; step(); step(); rst = 1'b0; clr();
    repeat (5) step();
    chk("t4_busy_sync", int'(busy), 0);
    idle(3); send(4, 3, 1'b1); idle(5);
    chk("t4_size", rxq.size(), 4);
    chk("t4_d0", (rxq.size() > 0) ? int'(rxq[0]) : -1, 3);
    chk("t4_fwd", int'(fwd), 1); chk("t4_len", int'(len), 4); chk("t4_drop", int'(drp), 0);

    // cfg_en drops mid-frame: current frame kept, next one dropped
    clr();
    for (int i = 0; i < 6; i++) begin
      tx_d = 4'(i + 1); tx_en = 1'b1;
      if (i == 2) cfg_en = 1'b0;
      step();
    end
    idle(1); send(4, 9, 1'b1); idle(5);
    chk("t5_size", rxq.size(), 6);
    chk("t5_fwd", int'(fwd), 2); chk("t5_drop", int'(drp), 1); chk("t5_len", int'(len), 4);
    cfg_en = 1'b1;

    // reset at nibble 3 flushes everything
    clr();
    tx_en = 1'b1; tx_d = 4'd1; step(); tx_d = 4'd2; step();
    tx_d = 4'd3; rst = 1'b1; step(); rst = 1'b0; clr();
    chk("t6_dv", int'(rx_dv), 0); chk("t6_fwd", int'(fwd), 0);
    chk("t6_drop", int'(drp), 0); chk("t6_len", int'(len), 0); chk("t6_busy", int'(busy), 0);
    repeat (3) step();
    chk("t6_busy_sync", int'(busy), 0);
    idle(4);
    chk("t6_flushed", rxq.size(), 0);
    send(3, 5, 1'b1); idle(5);
    chk("t6_size", rxq.size(), 3); chk("t6_fwd2", int'(fwd), 1); chk("t6_len2", int'(len), 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
